// File: rtl/sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : sprite_animator
// Brief    : Frame sequencer plus sprite hit-test / ROM realignment / color key.
// Revision : 1.0
// ============================================================================
module sprite_animator #(
    parameter int          SPR_W       = 40,
    parameter int          SPR_H       = 40,
    parameter int          NUM_FRAMES  = 8,
    parameter int          FRAME_W     = 3,
    parameter int          TICK_DIV    = 1,
    parameter int          ROM_LAT     = 1,
    parameter int          TRANS_EN    = 1,
    parameter logic [11:0] TRANS_COLOR = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               anim_tick,
    input  logic               start,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    output logic [5:0]         rom_row,
    output logic [5:0]         rom_col,
    output logic [FRAME_W-1:0] rom_frame,
    input  logic [11:0]        rom_pixel,
    output logic [11:0]        pixel_out,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_M_PING    = 2'd1;
    localparam logic [1:0] c_M_ONESHOT = 2'd2;
    localparam logic [1:0] c_M_STATIC  = 2'd3;

    localparam int                 c_DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);
    localparam logic [FRAME_W-1:0] c_LAST    = FRAME_W'(NUM_FRAMES - 1);

    // Hit test in 11 bits; the +SPR_W/2 offset lets the sprite clip at the left edge.
    logic [10:0] w_hx, w_px, w_py, w_vy;
    logic        w_area;

    assign w_hx   = {1'b0, hCount} + 11'(SPR_W / 2);
    assign w_px   = {1'b0, pos_x};
    assign w_py   = {1'b0, pos_y};
    assign w_vy   = {1'b0, vCount};
    assign w_area = (w_hx >= w_px) && (w_hx < w_px + 11'(SPR_W)) &&
                    (w_vy >= w_py) && (w_vy < w_py + 11'(SPR_H));

    assign rom_col = w_hx[5:0] - pos_x[5:0];
    assign rom_row = vCount[5:0] - pos_y[5:0];

    logic [ROM_LAT-1:0] r_area;

    generate
        if (ROM_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) r_area <= '0;
                else       r_area <= w_area;
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (reset) r_area <= '0;
                else       r_area <= {r_area[ROM_LAT-2:0], w_area};
            end
        end
    endgenerate

    logic w_key;
    assign w_key       = (TRANS_EN != 0) && (rom_pixel == TRANS_COLOR);
    assign pixel_valid = r_area[ROM_LAT-1] & ~w_key;
    assign pixel_out   = pixel_valid ? rom_pixel : 12'h000;

    logic [1:0]         r_state, w_state_next;
    logic [FRAME_W-1:0] r_frame, w_frame_next;
    logic               r_dir, w_dir_next;
    logic [c_DIV_W-1:0] r_div, w_div_next;
    logic [1:0]         r_mode, w_mode_next;
    logic               r_done, w_done_next;
    logic [FRAME_W-1:0] r_rom_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_frame     <= '0;
            r_dir       <= 1'b0;
            r_div       <= '0;
            r_mode      <= 2'd0;
            r_done      <= 1'b0;
            r_rom_frame <= '0;
        end else begin
            r_state <= w_state_next;
            r_frame <= w_frame_next;
            r_dir   <= w_dir_next;
            r_div   <= w_div_next;
            r_mode  <= w_mode_next;
            r_done  <= w_done_next;
            // Latching only at top-of-screen keeps a whole frame on one sprite image.
            if (hCount == 10'd0 && vCount == 10'd0)
                r_rom_frame <= r_frame;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        w_dir_next   = r_dir;
        w_div_next   = r_div;
        w_mode_next  = r_mode;
        w_done_next  = 1'b0;
        if (start) begin
            w_state_next = (mode == c_M_STATIC) ? c_IDLE : c_RUN;
            w_frame_next = '0;
            w_dir_next   = 1'b0;
            w_div_next   = '0;
            w_mode_next  = mode;
        end else begin
            case (r_state)
                c_IDLE: w_frame_next = '0;
                c_RUN: begin
                    if (!pause && anim_tick) begin
                        if (r_div == c_DIV_MAX) begin
                            w_div_next = '0;
                            case (r_mode)
                                c_M_PING: begin
                                    if (NUM_FRAMES == 1) begin
                                        w_frame_next = '0;
                                    end else if (!r_dir) begin
                                        if (r_frame == c_LAST) begin
                                            w_frame_next = r_frame - 1'b1;
                                            w_dir_next   = 1'b1;
                                        end else begin
                                            w_frame_next = r_frame + 1'b1;
                                        end
                                    end else begin
                                        if (r_frame == '0) begin
                                            w_frame_next = r_frame + 1'b1;
                                            w_dir_next   = 1'b0;
                                        end else begin
                                            w_frame_next = r_frame - 1'b1;
                                        end
                                    end
                                end
                                c_M_ONESHOT: begin
                                    if (r_frame == c_LAST) begin
                                        w_state_next = c_DONE;
                                        w_done_next  = 1'b1;
                                    end else begin
                                        w_frame_next = r_frame + 1'b1;
                                    end
                                end
                                default: w_frame_next = (r_frame == c_LAST) ? '0 : r_frame + 1'b1;
                            endcase
                        end else begin
                            w_div_next = r_div + 1'b1;
                        end
                    end
                end
                c_DONE:  w_frame_next = c_LAST;
                default: w_state_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state == c_RUN);
        done      = r_done;
        rom_frame = r_rom_frame;
    end

endmodule
`default_nettype wire
